// File: rtl/time_setter.sv
// time_setter: lets the user stop the time-of-day counter, edit hours,
// minutes and seconds with inc/dec buttons (single steps plus auto-repeat
// while held), then load the edited time back into the counter.
//
// Ports:
//   clk_i, rstn_i                        clock, async active-low reset
//   btn_config_i, btn_inc_i, btn_dec_i   debounced button levels
//   seconds_i, minutes_i, hours_i        live time from the counter
//   count_enable_o                       counter run enable (1 only in RUN)
//   load_time_o                          one-cycle load strobe on exit from SET_S
//   load_seconds_o/minutes_o/hours_o     shadow (edited) time
//   field_o                              0=none, 1=hours, 2=minutes, 3=seconds
//   blink_o                              selected field visible (1) / blanked (0)

// Per-button press detector with hold-to-repeat.
//   step pulses on the press cycle, again HOLD_CYCLES after the press, and then
//   every REPEAT_CYCLES while the button stays down.
module time_setter_repeat #(
    parameter int HOLD_CYCLES   = 50_000_000,
    parameter int REPEAT_CYCLES = 10_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic step
);
    localparam int MAXC = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    logic          prev;
    logic          act;   // armed: button went down after reset/release
    logic          rep;   // initial hold elapsed, now in repeat phase
    logic [CW-1:0] cnt;   // cycles since the last step
    logic          press;
    logic          hit;

    assign press = btn & ~prev;
    assign hit   = rep ? (cnt == CW'(REPEAT_CYCLES)) : (cnt == CW'(HOLD_CYCLES));
    assign step  = press | (btn & act & hit);

    // prev resets to 1 so a button held through reset stays silent until
    // released; act keeps such a held button from auto-repeating as well.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev <= 1'b1;
            act  <= 1'b0;
            rep  <= 1'b0;
            cnt  <= '0;
        end else begin
            prev <= btn;
            if (!btn) begin
                act <= 1'b0;
                rep <= 1'b0;
                cnt <= '0;
            end else if (press) begin
                act <= 1'b1;
                rep <= 1'b0;
                cnt <= CW'(1);
            end else if (act) begin
                if (hit) begin
                    rep <= 1'b1;
                    cnt <= CW'(1);
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end
        end
    end
endmodule

module time_setter #(
    parameter int HOLD_CYCLES   = 50_000_000,
    parameter int REPEAT_CYCLES = 10_000_000,
    parameter int BLINK_CYCLES  = 25_000_000
) (
    input  logic       clk_i,
    input  logic       rstn_i,
    input  logic       btn_config_i,
    input  logic       btn_inc_i,
    input  logic       btn_dec_i,
    input  logic [5:0] seconds_i,
    input  logic [5:0] minutes_i,
    input  logic [4:0] hours_i,
    output logic       count_enable_o,
    output logic       load_time_o,
    output logic [5:0] load_seconds_o,
    output logic [5:0] load_minutes_o,
    output logic [4:0] load_hours_o,
    output logic [1:0] field_o,
    output logic       blink_o
);
    // Encoding doubles as the field_o code.
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        SET_H = 2'd1,
        SET_M = 2'd2,
        SET_S = 2'd3
    } state_t;

    localparam int BW = $clog2(BLINK_CYCLES + 1);

    state_t        state, state_next;
    logic          cfg_prev;
    logic          cfg_ev;
    logic          inc_step, dec_step;
    logic          up, down;
    logic [5:0]    sh_s, sh_m;
    logic [4:0]    sh_h;
    logic [BW-1:0] bcnt;

    assign cfg_ev = btn_config_i & ~cfg_prev;

    time_setter_repeat #(.HOLD_CYCLES(HOLD_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES)) u_inc (
        .clk(clk_i), .rst_n(rstn_i), .btn(btn_inc_i), .step(inc_step)
    );
    time_setter_repeat #(.HOLD_CYCLES(HOLD_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES)) u_dec (
        .clk(clk_i), .rst_n(rstn_i), .btn(btn_dec_i), .step(dec_step)
    );

    // Config wins over inc/dec; coincident inc and dec cancel out.
    always_comb begin
        up   = 1'b0;
        down = 1'b0;
        if (state != RUN && !cfg_ev) begin
            up   = inc_step & ~dec_step;
            down = dec_step & ~inc_step;
        end
    end

    always_comb begin
        state_next = state;
        if (cfg_ev) begin
            case (state)
                RUN:     state_next = SET_H;
                SET_H:   state_next = SET_M;
                SET_M:   state_next = SET_S;
                default: state_next = RUN;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state          <= RUN;
            cfg_prev       <= 1'b1;
            count_enable_o <= 1'b1;
            load_time_o    <= 1'b0;
        end else begin
            state          <= state_next;
            cfg_prev       <= btn_config_i;
            count_enable_o <= (state_next == RUN);
            load_time_o    <= (state == SET_S) && cfg_ev;
        end
    end

    // Shadow registers. Out-of-range live values are replaced with 0 on
    // capture so the shadows never hold an illegal time.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sh_h <= '0;
            sh_m <= '0;
            sh_s <= '0;
        end else if (state == RUN && cfg_ev) begin
            sh_h <= (hours_i   > 5'd23) ? 5'd0 : hours_i;
            sh_m <= (minutes_i > 6'd59) ? 6'd0 : minutes_i;
            sh_s <= (seconds_i > 6'd59) ? 6'd0 : seconds_i;
        end else if (up || down) begin
            case (state)
                SET_H: begin
                    if (up) sh_h <= (sh_h >= 5'd23) ? 5'd0 : sh_h + 5'd1;
                    else    sh_h <= (sh_h == 5'd0 || sh_h > 5'd23) ? 5'd23 : sh_h - 5'd1;
                end
                SET_M: begin
                    if (up) sh_m <= (sh_m >= 6'd59) ? 6'd0 : sh_m + 6'd1;
                    else    sh_m <= (sh_m == 6'd0 || sh_m > 6'd59) ? 6'd59 : sh_m - 6'd1;
                end
                SET_S: begin
                    if (up) sh_s <= (sh_s >= 6'd59) ? 6'd0 : sh_s + 6'd1;
                    else    sh_s <= (sh_s == 6'd0 || sh_s > 6'd59) ? 6'd59 : sh_s - 6'd1;
                end
                default: ;
            endcase
        end
    end

    // Blink restarts visible on every field change or step so the user sees
    // the new value immediately.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            blink_o <= 1'b0;
            bcnt    <= '0;
        end else if (state_next == RUN) begin
            blink_o <= 1'b0;
            bcnt    <= '0;
        end else if (state_next != state || up || down) begin
            blink_o <= 1'b1;
            bcnt    <= '0;
        end else if (bcnt == BW'(BLINK_CYCLES - 1)) begin
            blink_o <= ~blink_o;
            bcnt    <= '0;
        end else begin
            bcnt    <= bcnt + BW'(1);
        end
    end

    assign field_o        = state;
    assign load_hours_o   = sh_h;
    assign load_minutes_o = sh_m;
    assign load_seconds_o = sh_s;
endmodule

// File: tb/tb_time_setter.sv
module tb_time_setter;
    localparam int HOLD   = 8;
    localparam int REPEAT = 4;
    localparam int BLINK  = 5;

    logic       clk, rstn, cfg, inc, dec;
    logic [5:0] sec, min;
    logic [4:0] hr;
    logic       cen, load, blink;
    logic [5:0] ls, lm;
    logic [4:0] lh;
    logic [1:0] field;

    int n_checks = 0;
    int n_fail   = 0;

    time_setter #(.HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REPEAT), .BLINK_CYCLES(BLINK)) dut (
        .clk_i(clk), .rstn_i(rstn),
        .btn_config_i(cfg), .btn_inc_i(inc), .btn_dec_i(dec),
        .seconds_i(sec), .minutes_i(min), .hours_i(hr),
        .count_enable_o(cen), .load_time_o(load),
        .load_seconds_o(ls), .load_minutes_o(lm), .load_hours_o(lh),
        .field_o(field), .blink_o(blink)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural reference model ----------------
    // mode: 0 run, 1 hours, 2 minutes, 3 seconds. age: cycles since a press
    // while the button stays down (-1 when not armed). since: cycles since
    // the last blink restart.
    int m_mode, m_h, m_m, m_s, m_ai, m_ad, m_since;
    bit m_pc, m_pi, m_pd, m_load, m_cen;

    function automatic bit rpt_step(input int age);
        return age == 0 || age == HOLD || (age > HOLD && (age - HOLD) % REPEAT == 0);
    endfunction

    always @(posedge clk) begin
        bit ce, si, sd;
        int nxt, d;
        if (!rstn) begin
            m_mode = 0; m_h = 0; m_m = 0; m_s = 0;
            m_ai = -1; m_ad = -1; m_since = 0;
            m_pc = 1; m_pi = 1; m_pd = 1; m_load = 0; m_cen = 1;
        end else begin
            ce = cfg && !m_pc;
            if (inc) m_ai = !m_pi ? 0 : (m_ai >= 0 ? m_ai + 1 : -1); else m_ai = -1;
            if (dec) m_ad = !m_pd ? 0 : (m_ad >= 0 ? m_ad + 1 : -1); else m_ad = -1;
            si = inc && m_ai >= 0 && rpt_step(m_ai);
            sd = dec && m_ad >= 0 && rpt_step(m_ad);
            m_pc = cfg; m_pi = inc; m_pd = dec;
            nxt    = ce ? (m_mode + 1) % 4 : m_mode;
            m_load = ce && m_mode == 3;
            m_cen  = (nxt == 0);
            d = 0;
            if (m_mode != 0 && !ce) d = int'(si) - int'(sd);
            if (ce && m_mode == 0) begin
                m_h = hr; m_m = min; m_s = sec;
            end else if (d != 0) begin
                case (m_mode)
                    1: m_h = (m_h + d + 24) % 24;
                    2: m_m = (m_m + d + 60) % 60;
                    default: m_s = (m_s + d + 60) % 60;
                endcase
            end
            if (nxt == 0 || nxt != m_mode || d != 0) m_since = 0;
            else m_since = m_since + 1;
            m_mode = nxt;
        end
    end

    function automatic logic [21:0] expv();
        logic eb;
        eb = (m_mode != 0) && ((m_since / BLINK) % 2 == 0);
        return {2'(m_mode), m_cen, m_load, 5'(m_h), 6'(m_m), 6'(m_s), eb};
    endfunction

    function automatic logic [21:0] obs();
        return {field, cen, load, lh, lm, ls, blink};
    endfunction

    // Drive buttons just after a falling edge, return at the next falling edge.
    task automatic cyc(input logic c, input logic i, input logic d);
        cfg = c; inc = i; dec = d;
        @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rstn = 1'b0; hr = 5'd3; min = 6'd4; sec = 6'd5;
        cyc(0, 0, 0); cyc(0, 0, 0);
        n_checks++;
        if (obs() !== {2'd0, 1'b1, 1'b0, 5'd0, 6'd0, 6'd0, 1'b0}) begin
            n_fail++; $display("FAIL reset_state: got %h exp %h", obs(), {2'd0, 1'b1, 1'b0, 5'd0, 6'd0, 6'd0, 1'b0});
        end
        rstn = 1'b1;
        cyc(0, 0, 0);
        n_checks++;
        if (obs() !== expv()) begin
            n_fail++; $display("FAIL reset_release: got %h exp %h", obs(), expv());
        end
    endtask

    task automatic test_enter();
        hr = 5'd12; min = 6'd34; sec = 6'd56;
        cyc(1, 0, 0);
        n_checks++;
        if (obs() !== {2'd1, 1'b0, 1'b0, 5'd12, 6'd34, 6'd56, 1'b1}) begin
            n_fail++; $display("FAIL enter_set_h: got %h exp %h", obs(), {2'd1, 1'b0, 1'b0, 5'd12, 6'd34, 6'd56, 1'b1});
        end
        hr = 5'd1; min = 6'd2; sec = 6'd3;
        repeat (3) begin
            cyc(0, 0, 0);
            n_checks++;
            if (obs() !== expv()) begin
                n_fail++; $display("FAIL shadow_hold: got %h exp %h", obs(), expv());
            end
        end
    endtask

    task automatic test_wrap();
        rstn = 1'b0; cyc(0, 0, 0); rstn = 1'b1; cyc(0, 0, 0);
        hr = 5'd23; min = 6'd0; sec = 6'd56;
        cyc(1, 0, 0); cyc(0, 0, 0);
        cyc(0, 1, 0);
        n_checks++;
        if (lh !== 5'd0 || obs() !== expv()) begin
            n_fail++; $display("FAIL hours_wrap_up: got hours %0d exp 0 (vec %h exp %h)", lh, obs(), expv());
        end
        cyc(0, 0, 0);
        cyc(1, 0, 0); cyc(0, 0, 0);
        cyc(0, 0, 1);
        n_checks++;
        if (lm !== 6'd59 || obs() !== expv()) begin
            n_fail++; $display("FAIL minutes_wrap_down: got minutes %0d exp 59 (vec %h exp %h)", lm, obs(), expv());
        end
        cyc(0, 0, 0);
        cyc(1, 0, 0); cyc(0, 0, 0);
    endtask

    task automatic test_repeat();
        // In SET_S with seconds at 56; inc high for 21 rising clock edges.
        repeat (21) begin
            cyc(0, 1, 0);
            n_checks++;
            if (obs() !== expv()) begin
                n_fail++; $display("FAIL repeat_cycle: got %h exp %h", obs(), expv());
            end
        end
        cyc(0, 0, 0);
        n_checks++;
        if (ls !== 6'd1 || field !== 2'd3) begin
            n_fail++; $display("FAIL repeat_total: got seconds %0d field %0d exp 1 and 3", ls, field);
        end
    endtask

    task automatic test_blink();
        repeat (14) begin
            cyc(0, 0, 0);
            n_checks++;
            if (obs() !== expv()) begin
                n_fail++; $display("FAIL blink_idle: got %h exp %h", obs(), expv());
            end
        end
    endtask

    task automatic test_exit();
        int pulses;
        cyc(1, 0, 0);
        n_checks++;
        if (obs() !== {2'd0, 1'b1, 1'b1, 5'd0, 6'd59, 6'd1, 1'b0}) begin
            n_fail++; $display("FAIL exit_load: got %h exp %h", obs(), {2'd0, 1'b1, 1'b1, 5'd0, 6'd59, 6'd1, 1'b0});
        end
        cyc(0, 0, 0);
        n_checks++;
        if (load !== 1'b0) begin
            n_fail++; $display("FAIL exit_load_one_cycle: got %b exp 0", load);
        end
        hr = 5'd7; min = 6'd8; sec = 6'd9;
        cyc(1, 0, 0); cyc(0, 0, 0);
        pulses = 0;
        for (int k = 0; k < 3; k++) begin
            cyc(1, 0, 0);
            pulses += int'(load);
            n_checks++;
            if (obs() !== expv()) begin
                n_fail++; $display("FAIL three_press: got %h exp %h", obs(), expv());
            end
            cyc(0, 0, 0);
            pulses += int'(load);
        end
        repeat (3) begin cyc(0, 0, 0); pulses += int'(load); end
        n_checks++;
        if (pulses != 1 || cen !== 1'b1 || field !== 2'd0) begin
            n_fail++; $display("FAIL load_pulse_count: got %0d pulses cen %b field %0d exp 1 1 0", pulses, cen, field);
        end
    endtask

    task automatic test_simul();
        int mm;
        hr = 5'd10; min = 6'd20; sec = 6'd30;
        cyc(1, 0, 0); cyc(0, 0, 0); cyc(1, 0, 0); cyc(0, 0, 0);
        mm = m_m;
        repeat (14) begin
            cyc(0, 1, 1);
            n_checks++;
            if (lm !== 6'(mm) || obs() !== expv()) begin
                n_fail++; $display("FAIL inc_dec_cancel: got minutes %0d exp %0d", lm, mm);
            end
        end
        cyc(0, 0, 0);
        cyc(1, 1, 0);
        n_checks++;
        if (field !== 2'd3 || lm !== 6'(mm) || obs() !== expv()) begin
            n_fail++; $display("FAIL config_priority: got field %0d minutes %0d exp 3 %0d", field, lm, mm);
        end
        cyc(0, 0, 0);
        cyc(1, 0, 0); cyc(0, 0, 0);
    endtask

    task automatic test_reset_mid();
        int pulses;
        cyc(1, 0, 0); cyc(0, 0, 0);
        cyc(1, 0, 0);                     // SET_M entered, config kept down
        n_checks++;
        if (field !== 2'd2) begin
            n_fail++; $display("FAIL mid_setup: got field %0d exp 2", field);
        end
        pulses = 0;
        rstn = 1'b0;
        cyc(1, 0, 0); pulses += int'(load);
        cyc(1, 0, 0); pulses += int'(load);
        rstn = 1'b1;
        repeat (6) begin
            cyc(1, 0, 0);
            pulses += int'(load);
            n_checks++;
            if (field !== 2'd0 || obs() !== expv()) begin
                n_fail++; $display("FAIL held_through_reset: got field %0d exp 0", field);
            end
        end
        cyc(0, 0, 0);
        pulses += int'(load);
        n_checks++;
        if (pulses != 0 || field !== 2'd0 || lh !== 5'd0) begin
            n_fail++; $display("FAIL reset_no_load: got %0d pulses field %0d exp 0 0", pulses, field);
        end
        cyc(1, 0, 0);
        n_checks++;
        if (field !== 2'd1 || obs() !== expv()) begin
            n_fail++; $display("FAIL repress_after_reset: got field %0d exp 1", field);
        end
        cyc(0, 0, 0);
    endtask

    task automatic test_random();
        logic c, i, d;
        c = 0; i = 0; d = 0;
        repeat (600) begin
            if ($urandom_range(0, 9) == 0) c = ~c;
            if ($urandom_range(0, 5) == 0) i = ~i;
            if ($urandom_range(0, 5) == 0) d = ~d;
            hr  = 5'($urandom_range(0, 23));
            min = 6'($urandom_range(0, 59));
            sec = 6'($urandom_range(0, 59));
            cyc(c, i, d);
            n_checks++;
            if (obs() !== expv()) begin
                n_fail++; $display("FAIL random: got %h exp %h", obs(), expv());
            end
        end
    endtask

    initial begin
        rstn = 1'b0; cfg = 1'b0; inc = 1'b0; dec = 1'b0;
        hr = '0; min = '0; sec = '0;
        @(negedge clk);
        test_reset();
        test_enter();
        test_wrap();
        test_repeat();
        test_blink();
        test_exit();
        test_simul();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/time_setter.md
TIME_SETTER -- requirements
Module: time_setter

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 50_000_000, cycles inc/dec must be held before auto-repeat starts.
REQ-002 SHALL have parameter REPEAT_CYCLES, default 10_000_000, cycles between auto-repeat steps.
REQ-003 SHALL have parameter BLINK_CYCLES, default 25_000_000, half-period of blink_o.
REQ-004 SHALL have port clk_i  in  1  system clock (one clock domain, 100 MHz).
REQ-005 SHALL have port rstn_i  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports btn_config_i, btn_inc_i, btn_dec_i  in  1 each  debounced button levels.
REQ-007 SHALL have ports seconds_i [5:0], minutes_i [5:0], hours_i [4:0]  in  live time from counter.
REQ-008 SHALL have port count_enable_o  out  1  counter run enable.
REQ-009 SHALL have port load_time_o  out  1  one-cycle load strobe to counter.
REQ-010 SHALL have ports load_seconds_o [5:0], load_minutes_o [5:0], load_hours_o [4:0]  out  shadow time values.
REQ-011 SHALL have port field_o [1:0]  out  0=none, 1=hours, 2=minutes, 3=seconds.
REQ-012 SHALL have port blink_o  out  1  selected field visible (1) / blanked (0).

Function
REQ-013 SHALL detect rising edges of each button with one registered previous-level flop; an event is the cycle after the edge.
REQ-014 SHALL implement FSM RUN -> SET_H -> SET_M -> SET_S -> RUN, advancing one state per btn_config_i event.
REQ-015 SHALL, on RUN->SET_H, copy seconds_i/minutes_i/hours_i into shadow registers in the same cycle.
REQ-016 SHALL drive count_enable_o=1 only in RUN (registered, state-decoded); 0 in all SET states.
REQ-017 SHALL, on SET_S->RUN, assert load_time_o for exactly one cycle, in the first cycle of RUN, with shadows stable on load_* outputs.
REQ-018 SHALL drive load_* from the shadow registers at all times; load_time_o is 0 except per REQ-017.
REQ-019 SHALL, in SET_H/SET_M/SET_S, step the selected shadow field +1 on inc event, -1 on dec event.
REQ-020 SHALL wrap hours 23->0 and 0->23, minutes/seconds 59->0 and 0->59; no out-of-range value ever held.
REQ-021 SHALL auto-repeat: button held HOLD_CYCLES after its edge -> one step, then one step every REPEAT_CYCLES while held; release stops and clears the hold counter.
REQ-022 SHALL ignore inc and dec (edges and repeats) in RUN.
REQ-023 SHALL, for simultaneous inc and dec events in one cycle, leave the field unchanged.
REQ-024 SHALL give config priority: config event in same cycle as inc/dec -> state advances, field unchanged.
REQ-025 SHALL toggle blink_o every BLINK_CYCLES in SET states; on state entry or any field step, force blink_o=1 and restart the blink counter; blink_o=0 in RUN.
REQ-026 SHALL drive field_o = 0/1/2/3 for RUN/SET_H/SET_M/SET_S.

Reset
REQ-027 SHALL, while rstn_i=0: state RUN, count_enable_o=1, load_time_o=0, shadows 0, field_o=0, blink_o=0, all counters 0.
REQ-028 SHALL reset edge-detect flops to 1, so a button held through reset generates no event until released and re-pressed.
REQ-029 SHALL, on reset mid-setting, abandon shadows without pulsing load_time_o.

Verification (bench uses HOLD=8, REPEAT=4, BLINK=5)
REQ-030 Time 12:34:56 live, config press -> field_o=1, count_enable_o=0, load_* = 12/34/56 next cycle.
REQ-031 SET_H at 23, one inc press -> hours 0; SET_M at 0, one dec press -> 59.
REQ-032 SET_S, inc held 20 cycles from edge -> 1 + 1 (cycle 8) + 3 repeats (12,16,20) = 5 steps, 56->1 with wrap.
REQ-033 Three config presses from SET_H -> RUN, load_time_o high exactly one cycle, count_enable_o=1.
REQ-034 Inc and dec edges same cycle in SET_M -> minutes unchanged; config+inc same cycle -> state advances, value unchanged.
REQ-035 Reset asserted in SET_M with config held -> RUN, no load_time_o, no event after rstn_i rises until config released/re-pressed.
